// File: rtl/edge_detector_pkg.sv
// Shared types for the multi-channel edge detector.
// Mode encodings and the per-channel debounce FSM states.
package edge_detector_pkg;

  localparam logic [1:0] MODE_RISE = 2'b00;
  localparam logic [1:0] MODE_FALL = 2'b01;
  localparam logic [1:0] MODE_BOTH = 2'b10;
  localparam logic [1:0] MODE_OFF  = 2'b11;

  typedef enum logic [1:0] {
    S_LOW      = 2'd0,
    S_RISE_CHK = 2'd1,
    S_HIGH     = 2'd2,
    S_FALL_CHK = 2'd3
  } state_t;

  function automatic logic rise_en(input logic [1:0] m);
    return (m == MODE_RISE) || (m == MODE_BOTH);
  endfunction

  function automatic logic fall_en(input logic [1:0] m);
    return (m == MODE_FALL) || (m == MODE_BOTH);
  endfunction

endpackage

// File: rtl/edge_detector_chan.sv
// One channel: synchroniser, debounce FSM and pulse stretcher.
// All outputs come straight from flops.
module edge_detector_chan
  import edge_detector_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int PULSE_CYCLES    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sig,
  input  logic [1:0] mode,
  output logic       edge_pulse,
  output logic       edge_dir,
  output logic       level
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int PW = $clog2(PULSE_CYCLES + 1);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [PW-1:0] P_LOAD  = PW'(PULSE_CYCLES);

  logic [SYNC_STAGES-1:0] sync;
  logic                   s;
  state_t                 state, nxt_state;
  logic [DW-1:0]          cnt, nxt_cnt;
  logic [PW-1:0]          pcnt;
  logic                   rise_q, fall_q, fire;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync <= '0;
    else      sync <= {sync[SYNC_STAGES-2:0], sig};
  end

  assign s = sync[SYNC_STAGES-1];

  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt;
    rise_q    = 1'b0;
    fall_q    = 1'b0;
    unique case (state)
      S_LOW: if (s) begin
        if (DEBOUNCE_CYCLES == 1) begin
          nxt_state = S_HIGH;
          rise_q    = 1'b1;
        end else begin
          nxt_state = S_RISE_CHK;
          nxt_cnt   = DW'(1);
        end
      end
      S_RISE_CHK: if (!s) begin
        nxt_state = S_LOW;
        nxt_cnt   = '0;
      end else if (cnt == DB_LAST) begin
        nxt_state = S_HIGH;
        nxt_cnt   = '0;
        rise_q    = 1'b1;
      end else begin
        nxt_cnt = cnt + DW'(1);
      end
      S_HIGH: if (!s) begin
        if (DEBOUNCE_CYCLES == 1) begin
          nxt_state = S_LOW;
          fall_q    = 1'b1;
        end else begin
          nxt_state = S_FALL_CHK;
          nxt_cnt   = DW'(1);
        end
      end
      S_FALL_CHK: if (s) begin
        nxt_state = S_HIGH;
        nxt_cnt   = '0;
      end else if (cnt == DB_LAST) begin
        nxt_state = S_LOW;
        nxt_cnt   = '0;
        fall_q    = 1'b1;
      end else begin
        nxt_cnt = cnt + DW'(1);
      end
      default: nxt_state = S_LOW;
    endcase
  end

  assign fire = (rise_q && rise_en(mode)) ||
                (fall_q && fall_en(mode));

  // A fire during a live pulse reloads rather than queues.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_LOW;
      cnt      <= '0;
      pcnt     <= '0;
      edge_dir <= 1'b0;
    end else begin
      state <= nxt_state;
      cnt   <= nxt_cnt;
      if (fire) begin
        pcnt     <= P_LOAD;
        edge_dir <= rise_q;
      end else if (pcnt != '0) begin
        pcnt <= pcnt - PW'(1);
      end
    end
  end

  assign edge_pulse = (pcnt != '0);
  assign level      = (state == S_HIGH) ||
                      (state == S_FALL_CHK);

endmodule

// File: rtl/edge_detector_multi.sv
// Multi-channel debounced edge detector for button/switch inputs.
// Channels are independent; mode is shared.
module edge_detector_multi
  import edge_detector_pkg::*;
#(
  parameter int CH              = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int PULSE_CYCLES    = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [CH-1:0] sig_in,
  input  logic [1:0]    mode,
  output logic [CH-1:0] edge_pulse,
  output logic [CH-1:0] edge_dir,
  output logic [CH-1:0] level_out
);

  for (genvar i = 0; i < CH; i++) begin : g_ch
    edge_detector_chan #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .PULSE_CYCLES    (PULSE_CYCLES)
    ) u_chan (
      .clk        (clk),
      .rst        (rst),
      .sig        (sig_in[i]),
      .mode       (mode),
      .edge_pulse (edge_pulse[i]),
      .edge_dir   (edge_dir[i]),
      .level      (level_out[i])
    );
  end

endmodule

// File: tb/tb_edge_detector_multi.sv
// Directed bench for edge_detector_multi across three parameter sets.
// a: defaults, b: PULSE_CYCLES=3, c: DEBOUNCE_CYCLES=1 PULSE_CYCLES=8.
module tb_edge_detector_multi;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [3:0] sig_a = '0, sig_b = '0, sig_c = '0;
  logic [3:0] pulse_a, dir_a, lvl_a;
  logic [3:0] pulse_b, dir_b, lvl_b;
  logic [3:0] pulse_c, dir_c, lvl_c;
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  edge_detector_multi dut_a (
    .clk(clk), .rst(rst), .sig_in(sig_a), .mode(mode),
    .edge_pulse(pulse_a), .edge_dir(dir_a), .level_out(lvl_a)
  );

  edge_detector_multi #(.PULSE_CYCLES(3)) dut_b (
    .clk(clk), .rst(rst), .sig_in(sig_b), .mode(mode),
    .edge_pulse(pulse_b), .edge_dir(dir_b), .level_out(lvl_b)
  );

  edge_detector_multi #(.DEBOUNCE_CYCLES(1), .PULSE_CYCLES(8)) dut_c (
    .clk(clk), .rst(rst), .sig_in(sig_c), .mode(mode),
    .edge_pulse(pulse_c), .edge_dir(dir_c), .level_out(lvl_c)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) step();
    n_cmp++;
    if ({pulse_a, dir_a, lvl_a} !== 12'h000) begin
      n_bad++;
      $display("FAIL reset_a got %h want 000", {pulse_a, dir_a, lvl_a});
    end
    n_cmp++;
    if ({pulse_b, dir_b, lvl_b, pulse_c, dir_c, lvl_c} !== 24'h0) begin
      n_bad++;
      $display("FAIL reset_bc got %h want 0",
               {pulse_b, dir_b, lvl_b, pulse_c, dir_c, lvl_c});
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_rise();
    logic [3:0] ep, el;
    mode = 2'b00;
    @(negedge clk);
    sig_a[0] = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      ep = (k == 6) ? 4'b0001 : 4'b0000;
      el = (k >= 6) ? 4'b0001 : 4'b0000;
      n_cmp++;
      if (pulse_a !== ep) begin
        n_bad++;
        $display("FAIL rise_pulse k=%0d got %b want %b", k, pulse_a, ep);
      end
      n_cmp++;
      if (lvl_a !== el) begin
        n_bad++;
        $display("FAIL rise_level k=%0d got %b want %b", k, lvl_a, el);
      end
      if (k >= 6) begin
        n_cmp++;
        if (dir_a !== 4'b0001) begin
          n_bad++;
          $display("FAIL rise_dir k=%0d got %b want 0001", k, dir_a);
        end
      end
    end
  endtask

  task automatic test_glitch();
    @(negedge clk);
    sig_a[1] = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    sig_a[1] = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      step();
      n_cmp++;
      if ({pulse_a[1], lvl_a[1]} !== 2'b00) begin
        n_bad++;
        $display("FAIL glitch k=%0d got p=%b l=%b want 0 0",
                 k, pulse_a[1], lvl_a[1]);
      end
    end
  endtask

  task automatic test_both_stretch();
    logic [3:0] ep, el;
    mode = 2'b10;
    for (int ph = 0; ph < 2; ph++) begin
      @(negedge clk);
      sig_b[2] = (ph == 0);
      for (int k = 1; k <= 20; k++) begin
        step();
        ep = (k >= 6 && k <= 8) ? 4'b0100 : 4'b0000;
        if (ph == 0) el = (k >= 6) ? 4'b0100 : 4'b0000;
        else         el = (k < 6)  ? 4'b0100 : 4'b0000;
        n_cmp++;
        if (pulse_b !== ep) begin
          n_bad++;
          $display("FAIL both_pulse ph=%0d k=%0d got %b want %b",
                   ph, k, pulse_b, ep);
        end
        n_cmp++;
        if (lvl_b !== el) begin
          n_bad++;
          $display("FAIL both_level ph=%0d k=%0d got %b want %b",
                   ph, k, lvl_b, el);
        end
        if (ph == 1 || k >= 6) begin
          n_cmp++;
          if (dir_b[2] !== ((ph == 0) || (k < 6))) begin
            n_bad++;
            $display("FAIL both_dir ph=%0d k=%0d got %b", ph, k, dir_b[2]);
          end
        end
      end
    end
  endtask

  task automatic test_mode_filter();
    logic ep, el;
    for (int m = 0; m < 2; m++) begin
      mode = (m == 0) ? 2'b01 : 2'b11;
      for (int ph = 0; ph < 2; ph++) begin
        @(negedge clk);
        sig_a[3] = (ph == 0);
        for (int k = 1; k <= 12; k++) begin
          step();
          ep = (m == 0) && (ph == 1) && (k == 6);
          el = (ph == 0) ? (k >= 6) : (k < 6);
          n_cmp++;
          if ({pulse_a[3], lvl_a[3]} !== {ep, el}) begin
            n_bad++;
            $display("FAIL filter m=%0d ph=%0d k=%0d got p=%b l=%b want %b %b",
                     m, ph, k, pulse_a[3], lvl_a[3], ep, el);
          end
        end
      end
    end
    n_cmp++;
    if (dir_a[3] !== 1'b0) begin
      n_bad++;
      $display("FAIL filter_dir got %b want 0", dir_a[3]);
    end
  endtask

  task automatic test_retrigger();
    logic ep, el, ed;
    mode = 2'b10;
    @(negedge clk);
    sig_c[0] = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      step();
      ep = (k >= 3 && k <= 13);
      el = (k >= 3 && k <= 5);
      n_cmp++;
      if ({pulse_c[0], lvl_c[0]} !== {ep, el}) begin
        n_bad++;
        $display("FAIL retrig k=%0d got p=%b l=%b want %b %b",
                 k, pulse_c[0], lvl_c[0], ep, el);
      end
      if (k >= 3) begin
        ed = (k <= 5);
        n_cmp++;
        if (dir_c[0] !== ed) begin
          n_bad++;
          $display("FAIL retrig_dir k=%0d got %b want %b", k, dir_c[0], ed);
        end
      end
      if (k == 3) begin
        @(negedge clk);
        sig_c[0] = 1'b0;
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] ea, ec;
    mode = 2'b00;
    @(negedge clk);
    sig_b = 4'hF;
    for (int k = 1; k <= 7; k++) begin
      step();
      if (k == 6) begin
        n_cmp++;
        if (pulse_b !== 4'hF) begin
          n_bad++;
          $display("FAIL mid_pre k=%0d got %b want 1111", k, pulse_b);
        end
      end
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({pulse_b, dir_b, lvl_b} !== 12'h000) begin
      n_bad++;
      $display("FAIL mid_async got %h want 000", {pulse_b, dir_b, lvl_b});
    end
    sig_a = 4'hF;
    sig_c = 4'hF;
    repeat (3) step();
    n_cmp++;
    if ({pulse_a, lvl_a, pulse_b, lvl_b, pulse_c, lvl_c} !== 24'h0) begin
      n_bad++;
      $display("FAIL mid_hold got %h want 0",
               {pulse_a, lvl_a, pulse_b, lvl_b, pulse_c, lvl_c});
    end
    @(negedge clk);
    rst = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step();
      ea = (k == 6) ? 4'hF : 4'h0;
      ec = (k >= 3) ? 4'hF : 4'h0;
      n_cmp++;
      if ({pulse_a, pulse_b, lvl_a} !== {ea, ea, ea}) begin
        n_bad++;
        $display("FAIL rel_ab k=%0d got pa=%b pb=%b la=%b want %b",
                 k, pulse_a, pulse_b, lvl_a, ea);
      end
      n_cmp++;
      if (pulse_c !== ec) begin
        n_bad++;
        $display("FAIL rel_c k=%0d got %b want %b", k, pulse_c, ec);
      end
    end
  endtask

  initial begin
    test_reset();
    test_rise();
    test_glitch();
    test_both_stretch();
    test_mode_filter();
    test_retrigger();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/edge_detector_multi.md
# edge_detector_multi

Parametrised multi-channel edge detector for the display's button/switch inputs. Each channel synchronises, debounces and edge-qualifies one asynchronous input, then emits a stretched, direction-tagged pulse. Rising, falling, both-edge or disabled detection is selectable at run time. It replaces the single-channel, rise-only, one-cycle pulse detector ahead of the text-scroll control logic.

## Interface
- CH, 4, number of independent input channels (>=1)
- SYNC_STAGES, 2, synchroniser flops per channel (>=2)
- DEBOUNCE_CYCLES, 4, consecutive cycles the synchronised input must differ from the accepted level before the level flips (>=1)
- PULSE_CYCLES, 1, width of each output pulse in clocks (>=1)

- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-low reset (0 = reset asserted; release synchronous to clk externally)
- sig_in  input  CH  raw asynchronous inputs, one bit per channel
- mode  input  2  detection mode, common to all channels: 00 rise, 01 fall, 10 both, 11 disabled
- edge_pulse  output  CH  registered pulse per channel, PULSE_CYCLES wide
- edge_dir  output  CH  direction of the most recent qualified edge: 1 rise, 0 fall
- level_out  output  CH  debounced, synchronised level per channel

## Operation
- Reset values: edge_pulse=0, edge_dir=0, level_out=0, synchroniser flops=0, all counters=0, every channel FSM in S_LOW.
- Per channel: SYNC_STAGES-deep synchroniser producing s; Moore FSM with states S_LOW, S_RISE_CHK, S_HIGH, S_FALL_CHK; debounce counter of width $clog2(DEBOUNCE_CYCLES+1); pulse counter of width $clog2(PULSE_CYCLES+1).
- S_LOW: s=1 -> S_RISE_CHK, counter=1 (if DEBOUNCE_CYCLES=1, go directly to S_HIGH). s=0 -> stay.
- S_RISE_CHK: s=0 -> S_LOW, counter cleared (glitch rejected, no pulse). s=1 and counter=DEBOUNCE_CYCLES-1 -> S_HIGH. Otherwise counter+1.
- S_HIGH / S_FALL_CHK: mirror image with s inverted.
- level_out = 1 in S_HIGH and S_FALL_CHK, else 0.
- Qualified edge is the transition into S_HIGH (rise) or into S_LOW from S_FALL_CHK (fall). It fires when mode permits: rise in 00/10, fall in 01/10, never in 11.
- On a fired edge: pulse counter loaded with PULSE_CYCLES, and edge_dir updated on the same edge. edge_pulse = (pulse counter != 0). The counter decrements to 0.
- Retrigger: a fired edge while the pulse counter is nonzero reloads it to PULSE_CYCLES, so the pulse is extended rather than doubled, and edge_dir takes the new direction.
- The level tracks in every mode. Mode 11 suppresses pulses only.
- mode is sampled only on the qualifying clock edge. Changing mode never truncates or creates an in-flight pulse.
- Channels are fully independent. Simultaneous edges on several channels each produce their own pulse.

## Timing
- Latency: the first clock edge that samples a new, stable sig_in value is edge 1. level_out and edge_pulse both change on edge SYNC_STAGES+DEBOUNCE_CYCLES (defaults: edge 6).
- edge_pulse stays high for exactly PULSE_CYCLES clocks when there is no retrigger.
- Rejection: any pulse shorter than DEBOUNCE_CYCLES clocks at the synchroniser output produces no level change and no pulse.
- Reset mid-operation: all outputs go to 0 immediately (asynchronous) and any in-flight pulse is dropped. After release, an input held at 1 yields one rise pulse at the normal latency, because the reset level is 0.
- No combinational path from any input to any output.

## Structure
- Package edge_detector_pkg holds:
  - the mode encodings (MODE_RISE, MODE_FALL, MODE_BOTH, MODE_OFF);
  - the 2-bit FSM state typedef and the S_* constants.
- Sub-module edge_detector_chan implements one channel: synchroniser, FSM, debounce counter and pulse counter, with mode as an input. The top instantiates CH copies in a generate loop.

## Test plan
- Reset and rise, defaults, mode=00: sig_in[0] 0->1 held -> level_out[0] and edge_pulse[0] rise on edge 6, pulse 1 cycle, edge_dir[0]=1. Other channels stay 0.
- Glitch rejection: 3-cycle high pulse on sig_in[1] with DEBOUNCE_CYCLES=4 -> no level_out or edge_pulse activity.
- Both-edge and stretch, mode=10, PULSE_CYCLES=3: 1 then 0 held 20 cycles each on channel 2 -> two 3-cycle pulses, edge_dir 1 then 0, level_out following with the same 6-cycle latency.
- Mode filtering: mode=01 with a rise then a fall -> only the fall pulses. mode=11 -> level_out toggles and edge_pulse stays 0.
- Retrigger, PULSE_CYCLES=8, DEBOUNCE_CYCLES=1: fall qualified 3 cycles after a rise -> a single continuous pulse, ending 8 cycles after the second edge, with edge_dir=0.
- Reset mid-pulse, then release with sig_in all 1s: outputs 0 during reset; all CH channels pulse together on edge 6 after release.
